// File: rtl/mcu_cpu_port_if.sv
// rtl/mcu_cpu_port_if.sv - cache, DMA and SDRAM-controller signals seen by the MCU CPU port
interface mcu_cpu_port_if;
  logic        dma_mcu_access;
  logic        mem_do_act;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_dataintomem;
  logic        mem_ack;
  logic [31:0] mem_datafrommem;
  logic        dma_req;
  logic        dma_grant;
  logic        ctl_cmd_valid;
  logic        ctl_cmd_ready;
  logic        ctl_cmd_we;
  logic [29:0] ctl_cmd_addr;
  logic [31:0] ctl_cmd_wdata;
  logic        ctl_rd_valid;
  logic [31:0] ctl_rd_data;

  modport slave (
    output dma_mcu_access, mem_ack, mem_datafrommem, dma_grant,
           ctl_cmd_valid, ctl_cmd_we, ctl_cmd_addr, ctl_cmd_wdata,
    input  mem_do_act, mem_we, mem_addr, mem_dataintomem, dma_req,
           ctl_cmd_ready, ctl_rd_valid, ctl_rd_data
  );

  modport master (
    input  dma_mcu_access, mem_ack, mem_datafrommem, dma_grant,
           ctl_cmd_valid, ctl_cmd_we, ctl_cmd_addr, ctl_cmd_wdata,
    output mem_do_act, mem_we, mem_addr, mem_dataintomem, dma_req,
           ctl_cmd_ready, ctl_rd_valid, ctl_rd_data
  );
endinterface

// File: rtl/mcu_cpu_port.sv
// rtl/mcu_cpu_port.sv - arbitrates the SDRAM command port between cache and DMA, replays reads on the cache refill schedule
module mcu_cpu_port #(
  parameter int DMA_MAX_CYC = 64
) (
  input  logic        MCU_CLK,
  input  logic        RST,
  mcu_cpu_port_if.slave bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_CMD, S_RDWAIT, S_ACK, S_GAP, S_DLV0, S_DLV1, S_HOLD, S_DMA
  } state_t;

  localparam logic [6:0] LP_DMA_MAX = 7'(DMA_MAX_CYC);

  state_t      r_state;
  state_t      w_next;

  logic        r_we;
  logic [29:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_word0;
  logic [31:0] r_word1;
  logic        r_beat;
  logic [1:0]  r_gap_cnt;
  logic [6:0]  r_dma_cnt;
  logic        r_dma_first;

  logic        r_access;
  logic        r_ack;
  logic [31:0] r_rdata;
  logic        r_grant;
  logic        r_cmd_valid;

  logic        w_access;
  logic        w_ack;
  logic [31:0] w_rdata;
  logic        w_grant;
  logic        w_cmd_valid;
  logic        w_latch;
  logic        w_capture;
  logic [6:0]  w_dma_held;

  // Held count includes the current cycle; saturates so it can never wrap back under the limit.
  assign w_dma_held = (r_dma_cnt == 7'h7f) ? 7'h7f : r_dma_cnt + 7'd1;

  always_ff @(posedge MCU_CLK or negedge RST) begin
    if (!RST) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.mem_do_act && !(r_dma_first && bus.dma_req)) w_next = S_CMD;
        else if (bus.dma_req)                                w_next = S_DMA;
      end
      S_CMD:    if (bus.ctl_cmd_ready) w_next = r_we ? S_ACK : S_RDWAIT;
      S_RDWAIT: if (bus.ctl_rd_valid && r_beat) w_next = S_ACK;
      S_ACK:    w_next = r_we ? S_HOLD : S_GAP;
      S_GAP:    if (r_gap_cnt == 2'd2) w_next = S_DLV0;
      S_DLV0:   w_next = S_DLV1;
      S_DLV1:   w_next = S_HOLD;
      S_HOLD:   w_next = S_IDLE;
      S_DMA:    if (!bus.dma_req || (w_dma_held >= LP_DMA_MAX)) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every port comes straight off a flop.
  always_comb begin
    w_access    = (w_next == S_IDLE);
    w_ack       = (w_next == S_ACK);
    w_grant     = (w_next == S_DMA);
    w_cmd_valid = (w_next == S_CMD);
    w_rdata     = r_rdata;
    if (w_next == S_DLV0) w_rdata = r_word0;
    if (w_next == S_DLV1) w_rdata = r_word1;
    w_latch     = (r_state == S_IDLE) && (w_next == S_CMD);
    w_capture   = bus.ctl_rd_valid &&
                  (((r_state == S_CMD) && bus.ctl_cmd_ready && !r_we) || (r_state == S_RDWAIT));
  end

  always_ff @(posedge MCU_CLK or negedge RST) begin
    if (!RST) begin
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_word0     <= '0;
      r_word1     <= '0;
      r_beat      <= 1'b0;
      r_gap_cnt   <= '0;
      r_dma_cnt   <= '0;
      r_dma_first <= 1'b0;
      r_access    <= 1'b1;
      r_ack       <= 1'b0;
      r_rdata     <= '0;
      r_grant     <= 1'b0;
      r_cmd_valid <= 1'b0;
    end else begin
      r_access    <= w_access;
      r_ack       <= w_ack;
      r_rdata     <= w_rdata;
      r_grant     <= w_grant;
      r_cmd_valid <= w_cmd_valid;
      if (w_latch) begin
        r_we    <= bus.mem_we;
        r_addr  <= bus.mem_addr[29:0];
        r_wdata <= bus.mem_dataintomem;
        r_beat  <= 1'b0;
      end
      if (w_capture) begin
        if (!r_beat) begin
          r_word0 <= bus.ctl_rd_data;
          r_beat  <= 1'b1;
        end else begin
          r_word1 <= bus.ctl_rd_data;
        end
      end
      r_gap_cnt <= (r_state == S_GAP) ? r_gap_cnt + 2'd1 : 2'd0;
      r_dma_cnt <= (r_state == S_DMA) ? w_dma_held : 7'd0;
      // DMA gets first pick only if it was kept waiting behind a CPU transaction.
      if ((r_state == S_HOLD) && (w_next == S_IDLE))     r_dma_first <= bus.dma_req;
      else if ((r_state == S_DMA) && (w_next == S_IDLE)) r_dma_first <= 1'b0;
    end
  end

  assign bus.dma_mcu_access  = r_access;
  assign bus.mem_ack         = r_ack;
  assign bus.mem_datafrommem = r_rdata;
  assign bus.dma_grant       = r_grant;
  assign bus.ctl_cmd_valid   = r_cmd_valid;
  assign bus.ctl_cmd_we      = r_we;
  assign bus.ctl_cmd_addr    = r_addr;
  assign bus.ctl_cmd_wdata   = r_wdata;

endmodule

// File: tb/tb_mcu_cpu_port.sv
// tb/tb_mcu_cpu_port.sv - directed self-checking bench for mcu_cpu_port
module tb_mcu_cpu_port;
  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  mcu_cpu_port_if bus();

  mcu_cpu_port #(.DMA_MAX_CYC(64)) dut (
    .MCU_CLK (clk),
    .RST     (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs are driven and outputs sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    n_tests++;
    if ({bus.dma_mcu_access, bus.mem_ack, bus.dma_grant, bus.ctl_cmd_valid, bus.ctl_cmd_we} !== 5'b10000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 10000",
        {bus.dma_mcu_access, bus.mem_ack, bus.dma_grant, bus.ctl_cmd_valid, bus.ctl_cmd_we});
    end
    n_tests++;
    if ({bus.ctl_cmd_addr, bus.ctl_cmd_wdata, bus.mem_datafrommem} !== 94'd0) begin
      n_fail++; $display("FAIL reset_data: got addr %h wdata %h rdata %h expected zeros",
        bus.ctl_cmd_addr, bus.ctl_cmd_wdata, bus.mem_datafrommem);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write();
    bus.mem_do_act = 1'b1; bus.mem_we = 1'b1;
    bus.mem_addr = 32'h100; bus.mem_dataintomem = 32'hDEADBEEF;
    tick();
    n_tests++;
    if ({bus.ctl_cmd_valid, bus.ctl_cmd_we, bus.ctl_cmd_addr, bus.ctl_cmd_wdata, bus.dma_mcu_access}
        !== {1'b1, 1'b1, 30'h100, 32'hDEADBEEF, 1'b0}) begin
      n_fail++; $display("FAIL wr_cmd: got v=%b we=%b a=%h d=%h acc=%b expected 1 1 100 deadbeef 0",
        bus.ctl_cmd_valid, bus.ctl_cmd_we, bus.ctl_cmd_addr, bus.ctl_cmd_wdata, bus.dma_mcu_access);
    end
    tick();
    tick();
    n_tests++;
    if ({bus.ctl_cmd_valid, bus.ctl_cmd_addr, bus.mem_ack} !== {1'b1, 30'h100, 1'b0}) begin
      n_fail++; $display("FAIL wr_hold_cmd: got v=%b a=%h ack=%b expected 1 100 0",
        bus.ctl_cmd_valid, bus.ctl_cmd_addr, bus.mem_ack);
    end
    bus.ctl_cmd_ready = 1'b1;
    tick();
    bus.ctl_cmd_ready = 1'b0;
    n_tests++;
    if ({bus.mem_ack, bus.ctl_cmd_valid, bus.dma_mcu_access} !== 3'b100) begin
      n_fail++; $display("FAIL wr_ack: got ack/v/acc %b expected 100",
        {bus.mem_ack, bus.ctl_cmd_valid, bus.dma_mcu_access});
    end
    tick();
    n_tests++;
    if ({bus.mem_ack, bus.dma_mcu_access} !== 2'b00) begin
      n_fail++; $display("FAIL wr_hold: got ack/acc %b expected 00", {bus.mem_ack, bus.dma_mcu_access});
    end
    tick();
    bus.mem_do_act = 1'b0;
    n_tests++;
    if ({bus.mem_ack, bus.dma_mcu_access, bus.ctl_cmd_valid} !== 3'b010) begin
      n_fail++; $display("FAIL wr_idle_a2: got ack/acc/v %b expected 010",
        {bus.mem_ack, bus.dma_mcu_access, bus.ctl_cmd_valid});
    end
    tick();
    n_tests++;
    if (bus.ctl_cmd_valid !== 1'b0) begin
      n_fail++; $display("FAIL wr_no_repeat: got valid %b expected 0", bus.ctl_cmd_valid);
    end
  endtask

  task automatic test_read();
    logic extra_ack;
    bus.mem_do_act = 1'b1; bus.mem_we = 1'b0; bus.mem_addr = 32'h205;
    tick();
    n_tests++;
    if ({bus.ctl_cmd_valid, bus.ctl_cmd_we, bus.ctl_cmd_addr} !== {1'b1, 1'b0, 30'h205}) begin
      n_fail++; $display("FAIL rd_cmd: got v=%b we=%b a=%h expected 1 0 205",
        bus.ctl_cmd_valid, bus.ctl_cmd_we, bus.ctl_cmd_addr);
    end
    bus.ctl_cmd_ready = 1'b1;
    tick();
    bus.ctl_cmd_ready = 1'b0;
    bus.ctl_rd_valid = 1'b1; bus.ctl_rd_data = 32'h11111111;
    tick();
    bus.ctl_rd_valid = 1'b0;
    tick();
    tick();
    bus.ctl_rd_valid = 1'b1; bus.ctl_rd_data = 32'h22222222;
    tick();
    bus.ctl_rd_valid = 1'b0;
    n_tests++;
    if ({bus.mem_ack, bus.mem_datafrommem} !== {1'b1, 32'h0}) begin
      n_fail++; $display("FAIL rd_ack: got ack=%b d=%h expected 1 00000000", bus.mem_ack, bus.mem_datafrommem);
    end
    extra_ack = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      tick();
      extra_ack = extra_ack | bus.mem_ack;
      if (i == 1) begin
        bus.ctl_rd_valid = 1'b1; bus.ctl_rd_data = 32'hBAD0BAD0;
      end
      if (i == 2) begin
        bus.ctl_rd_valid = 1'b0; bus.mem_do_act = 1'b0;
      end
      if (i == 4) begin
        n_tests++;
        if (bus.mem_datafrommem !== 32'h11111111) begin
          n_fail++; $display("FAIL rd_dlv0: got %h expected 11111111", bus.mem_datafrommem);
        end
      end
      if (i == 5) begin
        n_tests++;
        if (bus.mem_datafrommem !== 32'h22222222) begin
          n_fail++; $display("FAIL rd_dlv1: got %h expected 22222222", bus.mem_datafrommem);
        end
      end
      if (i == 6) begin
        n_tests++;
        if ({bus.mem_datafrommem, bus.dma_mcu_access} !== {32'h22222222, 1'b0}) begin
          n_fail++; $display("FAIL rd_hold: got d=%h acc=%b expected 22222222 0",
            bus.mem_datafrommem, bus.dma_mcu_access);
        end
      end
      if (i == 7) begin
        n_tests++;
        if (bus.dma_mcu_access !== 1'b1) begin
          n_fail++; $display("FAIL rd_idle_a7: got acc %b expected 1", bus.dma_mcu_access);
        end
      end
    end
    n_tests++;
    if (extra_ack !== 1'b0) begin
      n_fail++; $display("FAIL rd_ack_repeat: got %b expected 0", extra_ack);
    end
  endtask

  task automatic test_fairness();
    bus.dma_req = 1'b1;
    bus.mem_do_act = 1'b1; bus.mem_we = 1'b1; bus.mem_addr = 32'h40; bus.mem_dataintomem = 32'h12345678;
    tick();
    bus.ctl_cmd_ready = 1'b1;
    tick();
    bus.ctl_cmd_ready = 1'b0;
    bus.mem_do_act = 1'b0;
    tick();
    tick();
    bus.mem_do_act = 1'b1; bus.mem_addr = 32'h80; bus.mem_dataintomem = 32'hCAFEF00D;
    tick();
    n_tests++;
    if ({bus.dma_grant, bus.dma_mcu_access, bus.ctl_cmd_valid} !== 3'b100) begin
      n_fail++; $display("FAIL fair_dma_wins: got grant/acc/v %b expected 100",
        {bus.dma_grant, bus.dma_mcu_access, bus.ctl_cmd_valid});
    end
    tick();
    tick();
    bus.dma_req = 1'b0;
    tick();
    n_tests++;
    if ({bus.dma_grant, bus.dma_mcu_access} !== 2'b01) begin
      n_fail++; $display("FAIL fair_dma_release: got grant/acc %b expected 01", {bus.dma_grant, bus.dma_mcu_access});
    end
    tick();
    n_tests++;
    if ({bus.ctl_cmd_valid, bus.ctl_cmd_addr, bus.ctl_cmd_wdata} !== {1'b1, 30'h80, 32'hCAFEF00D}) begin
      n_fail++; $display("FAIL fair_cpu_next: got v=%b a=%h d=%h expected 1 80 cafef00d",
        bus.ctl_cmd_valid, bus.ctl_cmd_addr, bus.ctl_cmd_wdata);
    end
    bus.ctl_cmd_ready = 1'b1;
    tick();
    bus.ctl_cmd_ready = 1'b0;
    bus.mem_do_act = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_dma_timeout();
    int n;
    bus.dma_req = 1'b1;
    tick();
    n = 0;
    while ((bus.dma_grant === 1'b1) && (n < 200)) begin
      n++;
      if (n == 10) begin
        bus.mem_do_act = 1'b1; bus.mem_we = 1'b1;
        bus.mem_addr = 32'h300; bus.mem_dataintomem = 32'h55AA55AA;
      end
      tick();
    end
    n_tests++;
    if (n !== 64) begin
      n_fail++; $display("FAIL dma_grant_cycles: got %0d expected 64", n);
    end
    tick();
    n_tests++;
    if ({bus.ctl_cmd_valid, bus.dma_grant, bus.ctl_cmd_addr} !== {1'b1, 1'b0, 30'h300}) begin
      n_fail++; $display("FAIL dma_cpu_after_revoke: got v=%b grant=%b a=%h expected 1 0 300",
        bus.ctl_cmd_valid, bus.dma_grant, bus.ctl_cmd_addr);
    end
    bus.ctl_cmd_ready = 1'b1;
    tick();
    bus.ctl_cmd_ready = 1'b0;
    bus.mem_do_act = 1'b0;
    tick();
    tick();
    tick();
    n_tests++;
    if (bus.dma_grant !== 1'b1) begin
      n_fail++; $display("FAIL dma_regrant: got %b expected 1", bus.dma_grant);
    end
    bus.dma_req = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset_midread();
    bus.mem_do_act = 1'b1; bus.mem_we = 1'b0; bus.mem_addr = 32'h10;
    tick();
    bus.ctl_cmd_ready = 1'b1; bus.ctl_rd_valid = 1'b1; bus.ctl_rd_data = 32'hAAAA0000;
    tick();
    bus.ctl_cmd_ready = 1'b0; bus.ctl_rd_valid = 1'b0; bus.mem_do_act = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({bus.dma_mcu_access, bus.mem_ack, bus.dma_grant, bus.ctl_cmd_valid, bus.ctl_cmd_we,
         bus.ctl_cmd_addr, bus.ctl_cmd_wdata, bus.mem_datafrommem} !== {5'b10000, 94'd0}) begin
      n_fail++; $display("FAIL async_reset: got acc=%b ack=%b g=%b v=%b a=%h d=%h rd=%h expected 1 0 0 0 0 0 0",
        bus.dma_mcu_access, bus.mem_ack, bus.dma_grant, bus.ctl_cmd_valid,
        bus.ctl_cmd_addr, bus.ctl_cmd_wdata, bus.mem_datafrommem);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    bus.mem_do_act = 1'b1; bus.mem_we = 1'b0; bus.mem_addr = 32'h11;
    tick();
    n_tests++;
    if ({bus.ctl_cmd_valid, bus.ctl_cmd_addr} !== {1'b1, 30'h11}) begin
      n_fail++; $display("FAIL post_reset_cmd: got v=%b a=%h expected 1 11", bus.ctl_cmd_valid, bus.ctl_cmd_addr);
    end
    bus.ctl_cmd_ready = 1'b1; bus.ctl_rd_valid = 1'b1; bus.ctl_rd_data = 32'h33333333;
    tick();
    bus.ctl_cmd_ready = 1'b0; bus.ctl_rd_valid = 1'b0;
    tick();
    bus.ctl_rd_valid = 1'b1; bus.ctl_rd_data = 32'h44444444;
    tick();
    bus.ctl_rd_valid = 1'b0;
    n_tests++;
    if (bus.mem_ack !== 1'b1) begin
      n_fail++; $display("FAIL post_reset_ack: got %b expected 1", bus.mem_ack);
    end
    tick();
    tick();
    bus.mem_do_act = 1'b0;
    tick();
    tick();
    n_tests++;
    if (bus.mem_datafrommem !== 32'h33333333) begin
      n_fail++; $display("FAIL post_reset_dlv0: got %h expected 33333333", bus.mem_datafrommem);
    end
    tick();
    n_tests++;
    if (bus.mem_datafrommem !== 32'h44444444) begin
      n_fail++; $display("FAIL post_reset_dlv1: got %h expected 44444444", bus.mem_datafrommem);
    end
    tick();
    tick();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0;
    bus.mem_do_act = 1'b0; bus.mem_we = 1'b0; bus.mem_addr = '0; bus.mem_dataintomem = '0;
    bus.dma_req = 1'b0; bus.ctl_cmd_ready = 1'b0; bus.ctl_rd_valid = 1'b0; bus.ctl_rd_data = '0;
    test_reset();
    test_write();
    test_read();
    test_fairness();
    test_dma_timeout();
    test_reset_midread();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
